// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: multi-channel BCD alarm matcher with one shared ring/snooze FSM,
// ring auto-off, BCD snooze arithmetic with midnight wrap, and clock/alarm display mux.
module multi_alarm_ctrl #(
    parameter  int NUM_ALARMS   = 4,
    parameter  int SNOOZE_MIN   = 5,
    parameter  int MAX_SNOOZE   = 3,
    parameter  int RING_TIMEOUT = 10,
    localparam int CH_W         = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    minute_tick,
    input  logic [15:0]             current_time,
    input  logic [16*NUM_ALARMS-1:0] alarm_time,
    input  logic [NUM_ALARMS-1:0]   alarm_enable,
    input  logic                    do_snooze,
    input  logic                    stop_alarm,
    input  logic                    show_alarm,
    input  logic [CH_W-1:0]         show_sel,
    output logic [15:0]             display,
    output logic                    sound_alarm,
    output logic [CH_W-1:0]         ringing_ch,
    output logic [15:0]             snooze_time,
    output logic [3:0]              snooze_count,
    output logic                    alarm_missed,
    output logic [2:0]              state_out
);
    localparam int RM_W = RING_TIMEOUT > 1 ? $clog2(RING_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, RINGING, SNOOZE_CALC, SNOOZING, ACK} state_t;

    state_t          state, next_state;
    logic [RM_W-1:0] ring_min;
    logic            hit, match, timeout;
    logic [CH_W-1:0] hit_ch;

    function automatic logic [15:0] add_snooze(input logic [15:0] t);
        logic [6:0] h, m;
        h = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
        m = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
        if (m >= 7'd60) begin
            m = m - 7'd60;
            h = h + 7'd1;
        end
        if (h >= 7'd24) h = h - 7'd24;
        return {4'(h / 7'd10), 4'(h % 7'd10), 4'(m / 7'd10), 4'(m % 7'd10)};
    endfunction

    assign display = show_alarm && int'(show_sel) < NUM_ALARMS
                     ? alarm_time[16*int'(show_sel) +: 16] : current_time;
    assign state_out = state;

    // descending scan so the lowest matching channel wins
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (alarm_enable[i] && alarm_time[16*i +: 16] == current_time) begin
                hit    = 1'b1;
                hit_ch = CH_W'(i);
            end
    end

    assign match   = minute_tick && hit;
    assign timeout = RING_TIMEOUT != 0 && minute_tick && ring_min == RM_W'(RING_TIMEOUT - 1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        next_state = match ? RINGING : IDLE;
            RINGING:     next_state = stop_alarm ? ACK
                                    : (do_snooze && snooze_count < 4'(MAX_SNOOZE)) ? SNOOZE_CALC
                                    : timeout ? ACK : RINGING;
            SNOOZE_CALC: next_state = SNOOZING;
            SNOOZING:    next_state = stop_alarm ? ACK
                                    : (minute_tick && current_time == snooze_time) ? RINGING : SNOOZING;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sound_alarm  <= 1'b0;
            alarm_missed <= 1'b0;
            ringing_ch   <= '0;
            ring_min     <= '0;
            snooze_time  <= '0;
            snooze_count <= '0;
        end else begin
            state        <= next_state;
            sound_alarm  <= next_state == RINGING;
            alarm_missed <= match && state != IDLE;
            if (state == IDLE && match) ringing_ch <= hit_ch;
            if (next_state == RINGING && state != RINGING) ring_min <= '0;
            else if (state == RINGING && minute_tick) ring_min <= ring_min + 1'b1;
            if (state == SNOOZE_CALC) begin
                snooze_time  <= add_snooze(current_time);
                snooze_count <= snooze_count + 4'd1;
            end else if (state != IDLE && next_state == IDLE) begin
                snooze_time  <= '0;
                snooze_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed scenarios checked every cycle against a minute-count
// behavioural model, plus literal expectations at key points.
module tb_multi_alarm_ctrl;
    localparam int N = 4, SNZ = 5, MAXS = 3, RT = 10, CW = 2;

    logic            clk = 0, reset_n = 0, minute_tick = 0;
    logic [15:0]     current_time = '0;
    logic [16*N-1:0] alarm_time = '0;
    logic [N-1:0]    alarm_enable = '0;
    logic            do_snooze = 0, stop_alarm = 0, show_alarm = 0;
    logic [CW-1:0]   show_sel = '0;
    logic [15:0]     display, snooze_time;
    logic            sound_alarm, alarm_missed;
    logic [CW-1:0]   ringing_ch;
    logic [3:0]      snooze_count;
    logic [2:0]      state_out;

    int checks = 0, errors = 0;

    multi_alarm_ctrl #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_TIMEOUT(RT)) dut (
        .clk(clk), .reset_n(reset_n), .minute_tick(minute_tick), .current_time(current_time),
        .alarm_time(alarm_time), .alarm_enable(alarm_enable), .do_snooze(do_snooze),
        .stop_alarm(stop_alarm), .show_alarm(show_alarm), .show_sel(show_sel),
        .display(display), .sound_alarm(sound_alarm), .ringing_ch(ringing_ch),
        .snooze_time(snooze_time), .snooze_count(snooze_count), .alarm_missed(alarm_missed),
        .state_out(state_out));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // time arithmetic done in minutes since midnight, then re-encoded as BCD
    function automatic logic [15:0] add_min(input logic [15:0] t, input int k);
        int mins;
        mins = ((int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]) + k) % 1440;
        return {4'(mins / 600), 4'((mins / 60) % 10), 4'((mins % 60) / 10), 4'(mins % 10)};
    endfunction

    int            ms = 0, m_cnt = 0, m_rmin = 0, hit;
    logic [CW-1:0] m_ch = '0;
    logic [15:0]   m_snz = '0, exp_disp;
    logic          m_missed = 0, m_sound = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms = 0; m_cnt = 0; m_rmin = 0; m_ch = '0; m_snz = '0; m_missed = 0; m_sound = 0;
        end else begin
            hit = -1;
            if (minute_tick)
                for (int i = N - 1; i >= 0; i--)
                    if (alarm_enable[i] && alarm_time[16*i +: 16] == current_time) hit = i;
            m_missed = hit >= 0 && ms != 0;
            case (ms)
                0: if (hit >= 0) begin ms = 1; m_ch = CW'(hit); m_rmin = 0; end
                1: begin
                    if (stop_alarm) ms = 4;
                    else if (do_snooze && m_cnt < MAXS) ms = 2;
                    else if (minute_tick) begin
                        m_rmin++;
                        if (RT != 0 && m_rmin >= RT) ms = 4;
                    end
                end
                2: begin m_snz = add_min(current_time, SNZ); m_cnt++; ms = 3; end
                3: begin
                    if (stop_alarm) ms = 4;
                    else if (minute_tick && current_time == m_snz) begin ms = 1; m_rmin = 0; end
                end
                default: begin m_cnt = 0; m_snz = '0; ms = 0; end
            endcase
            m_sound = ms == 1;
        end
    end

    always @(negedge clk) begin
        exp_disp = show_alarm && int'(show_sel) < N ? alarm_time[16*int'(show_sel) +: 16] : current_time;
        chk("display", 32'(display), 32'(exp_disp));
        chk("sound_alarm", 32'(sound_alarm), 32'(m_sound));
        chk("ringing_ch", 32'(ringing_ch), 32'(m_ch));
        chk("snooze_time", 32'(snooze_time), 32'(m_snz));
        chk("snooze_count", 32'(snooze_count), 32'(m_cnt));
        chk("alarm_missed", 32'(alarm_missed), 32'(m_missed));
        chk("state", 32'(state_out), 32'(ms));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick(input logic [15:0] t);
        current_time = t;
        minute_tick  = 1;
        cyc(1);
        minute_tick  = 0;
    endtask

    task automatic snooze();
        do_snooze = 1; cyc(1); do_snooze = 0;
    endtask

    task automatic stop();
        stop_alarm = 1; cyc(1); stop_alarm = 0;
    endtask

    task automatic set_alarm(input int ch, input logic [15:0] t);
        alarm_time[16*ch +: 16] = t;
    endtask

    logic [15:0] run_times[9] = '{16'h0817, 16'h0818, 16'h0819, 16'h0820, 16'h0821,
                                  16'h0822, 16'h0823, 16'h0824, 16'h0825};
    logic [15:0] run9[9] = '{16'h0901, 16'h0902, 16'h0903, 16'h0904, 16'h0905,
                             16'h0906, 16'h0907, 16'h0908, 16'h0909};

    initial begin
        #3;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_sound", 32'(sound_alarm), 32'd0);
        #9 reset_n = 1;
        cyc(1);

        set_alarm(0, 16'h0700); alarm_enable = 4'b0001;
        tick(16'h0700);
        chk("s1_state", 32'(state_out), 32'd1);
        chk("s1_sound", 32'(sound_alarm), 32'd1);
        chk("s1_ch", 32'(ringing_ch), 32'd0);
        stop();
        chk("s1_ack", 32'(state_out), 32'd4);
        cyc(3);
        chk("s1_no_retrigger", 32'(state_out), 32'd0);

        set_alarm(0, 16'h2357);
        tick(16'h2357);
        snooze();
        chk("s2_calc", 32'(state_out), 32'd2);
        cyc(1);
        chk("s2_snoozing", 32'(state_out), 32'd3);
        chk("s2_snz_time", 32'(snooze_time), 32'h0002);
        chk("s2_snz_cnt", 32'(snooze_count), 32'd1);
        tick(16'h2358); tick(16'h2359); tick(16'h0000); tick(16'h0001);
        chk("s2_still_snoozing", 32'(state_out), 32'd3);
        tick(16'h0002);
        chk("s2_rering", 32'(sound_alarm), 32'd1);

        snooze(); cyc(1);
        chk("s3_snz2", 32'(snooze_time), 32'h0007);
        tick(16'h0007);
        snooze(); cyc(1);
        chk("s3_snz3", 32'(snooze_count), 32'd3);
        tick(16'h0012);
        snooze();
        chk("s3_4th_ignored", 32'(state_out), 32'd1);
        chk("s3_sound_held", 32'(sound_alarm), 32'd1);
        stop(); cyc(1);
        chk("s3_idle", 32'(state_out), 32'd0);
        chk("s3_cnt_clr", 32'(snooze_count), 32'd0);

        set_alarm(1, 16'h0815); set_alarm(2, 16'h0815); set_alarm(3, 16'h0816);
        alarm_enable = 4'b1110;
        tick(16'h0815);
        chk("s4_ch", 32'(ringing_ch), 32'd1);
        tick(16'h0816);
        chk("s4_missed", 32'(alarm_missed), 32'd1);
        chk("s4_still_ring", 32'(state_out), 32'd1);
        cyc(1);
        chk("s4_missed_pulse", 32'(alarm_missed), 32'd0);

        alarm_enable = '0;
        for (int i = 0; i < 8; i++) tick(run_times[i]);
        chk("s5_before_timeout", 32'(sound_alarm), 32'd1);
        tick(run_times[8]);
        chk("s5_timeout_ack", 32'(state_out), 32'd4);
        chk("s5_sound_off", 32'(sound_alarm), 32'd0);
        cyc(1);
        chk("s5_idle", 32'(state_out), 32'd0);

        set_alarm(1, 16'h0830); alarm_enable = 4'b0010;
        tick(16'h0830);
        do_snooze = 1; stop_alarm = 1; cyc(1); do_snooze = 0; stop_alarm = 0;
        chk("s5_stop_priority", 32'(state_out), 32'd4);
        cyc(1);

        set_alarm(1, 16'h0900);
        tick(16'h0900);
        for (int i = 0; i < 9; i++) tick(run9[i]);
        do_snooze = 1; tick(16'h0910); do_snooze = 0;
        chk("s5_req_beats_timeout", 32'(state_out), 32'd2);
        cyc(1);
        chk("s5_snz_0915", 32'(snooze_time), 32'h0915);

        #1 reset_n = 0;
        #1;
        chk("s6_rst_state", 32'(state_out), 32'd0);
        chk("s6_rst_snz", 32'(snooze_time), 32'd0);
        chk("s6_rst_cnt", 32'(snooze_count), 32'd0);
        set_alarm(2, 16'h1234);
        show_alarm = 1; show_sel = 2'd2;
        #1 chk("s6_display_alarm2", 32'(display), 32'h1234);
        show_alarm = 0;
        #1 chk("s6_display_clock", 32'(display), 32'(current_time));
        #3 reset_n = 1;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
